// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Reset value of register `index`: its own index, or zero.
  function automatic logic [63:0] rf_init_val(input int unsigned index, input bit rst_index);
    return rst_index ? 64'(index) : 64'd0;
  endfunction

  // Low bit of slot k in a packed bus of w-bit slots.
  function automatic int unsigned slot_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: picks the highest-index same-cycle writer, applies the bypass,
// and qualifies the pending bit.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic                     stored_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              addr_nz;

  assign addr_nz = (rd_addr != '0);

  // Ascending scan so the highest-index matching writer is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[slot_lo(w, ADDR_W) +: ADDR_W] == rd_addr)) begin
        hit      = 1'b1;
        hit_data = wr_data[slot_lo(w, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (addr_nz) begin
      if ((BYPASS != 0) && hit) begin
        rd_data = hit_data;
      end else begin
        rd_data = stored_data;
        rd_busy = stored_pending;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with write-to-read bypass and a
// per-register pending scoreboard for ID-stage hazard detection.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int RST_INDEX = 1,
  parameter int BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     sb_flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [NUM_WR-1:0] wr_en_eff;

  // Writes to register 0 are dropped here so every consumer sees them as no-ops.
  always_comb begin
    wr_en_eff = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_en_eff[w] = wr_en[w] && !rst && (wr_addr[slot_lo(w, ADDR_W) +: ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(rf_init_val(i, RST_INDEX != 0));
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_eff[w]) begin
          mem_q[wr_addr[slot_lo(w, ADDR_W) +: ADDR_W]] <= wr_data[slot_lo(w, DATA_W) +: DATA_W];
        end
      end
    end
  end

  // Applied lowest priority first: write-clear, then set, then flush.
  always_comb begin
    pending_d = pending_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_eff[w]) begin
        pending_d[wr_addr[slot_lo(w, ADDR_W) +: ADDR_W]] = 1'b0;
      end
    end
    if (sb_set_en && (sb_set_addr != '0)) begin
      pending_d[sb_set_addr] = 1'b1;
    end
    if (sb_flush) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr_k;
      logic [DATA_W-1:0] stored_k;
      logic              pend_k;

      assign addr_k   = rd_addr[slot_lo(gi, ADDR_W) +: ADDR_W];
      // While rst is held the port already shows the value the register is resetting to.
      assign stored_k = rst ? DATA_W'(rf_init_val(32'(addr_k), RST_INDEX != 0)) : mem_q[addr_k];
      assign pend_k   = pending_q[addr_k] && !rst;

      reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
      ) u_rd_port (
        .rd_addr        (addr_k),
        .stored_data    (stored_k),
        .stored_pending (pend_k),
        .wr_en          (wr_en_eff),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_data        (rd_data[slot_lo(gi, DATA_W) +: DATA_W]),
        .rd_busy        (rd_busy[gi])
      );
    end
  endgenerate

endmodule
